// File: rtl/uart_tx_fifo_if.sv
// Byte-producer side of the buffered UART transmitter.
// A byte transfers on a rising clk edge where in_valid && in_ready are both high;
// in_data must be stable while in_valid is high, and in_ready never depends on in_valid.
interface uart_tx_fifo_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter (optional parity) fed from a byte FIFO.
// Back-to-back frames leave STOP straight into START while bytes are queued.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  uart_tx_fifo_if.slave                     in_if,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic [2:0]                        dbg_state_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e          state_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic            tx_q;
  logic            busy_q;

  logic            in_ready;
  logic            push;
  logic            pop;
  logic            baud_last;
  logic            fifo_nonempty;
  logic [7:0]      head;

  // in_ready is held low combinationally while rst is asserted.
  assign in_ready      = !rst && (count_q != CW'(FIFO_DEPTH));
  assign push          = in_if.in_valid && in_ready;
  assign baud_last     = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign fifo_nonempty = (count_q != '0);
  assign pop           = fifo_nonempty &&
                         ((state_q == IDLE) || ((state_q == STOP) && baud_last));
  assign head          = mem_q[rd_ptr_q];

  assign in_if.in_ready = in_ready;
  assign tx             = tx_q;
  assign busy           = busy_q;
  assign fifo_count     = count_q;
  assign dbg_state_o    = state_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_if.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      // Parity is computed once from the popped byte, before shifting destroys it.
      if (pop) begin
        shift_q <= head;
        par_q   <= (^head) ^ (PARITY_ODD != 0);
      end

      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          baud_q <= '0;
          if (pop) begin
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[1];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        PARITY: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          baud_q  <= '0;
        end
      endcase
    end
  end

endmodule
